echo_receiver: RTL and testbench



---
 rtl/echo_pkg.sv | 21 ++
 rtl/echo_sync.sv | 35 +++
 rtl/echo_receiver.sv | 138 +++++++++++++
 tb/tb_echo_receiver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the ultrasonic echo path: FSM states and timing constants.
package echo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitRise,
        StMeasure,
        StWaitLow
    } state_e;

    // Echo round trip: 58 us of echo-high time per centimetre of distance.
    localparam int unsigned US_PER_CM = 58;

    // The system clock runs at 1 MHz, so one cycle is one microsecond.
    localparam int unsigned CLK_PERIOD_NS = 1000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Brings the raw sensor echo into the clk domain and flags its edges.
module echo_sync (
    input  logic clk,
    input  logic clr,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic echo_d;

    // Two synchronizer stages followed by one delay stage for edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            meta_q <= echo;
            sync_q <= meta_q;
            echo_d <= sync_q;
        end
    end

    // Edge events are relative to the previous synchronized sample.
    always_comb begin
        echo_s = sync_q;
        rise   = sync_q & ~echo_d;
        fall   = ~sync_q & echo_d;
    end

endmodule

// File: rtl/echo_receiver.sv
// Measures the echo pulse width and converts it to whole centimetres without a divider.
module echo_receiver #(
    parameter int unsigned US_PER_CM    = echo_pkg::US_PER_CM,
    parameter int unsigned RISE_TIMEOUT = 1000,
    parameter int unsigned MAX_ECHO     = 30000,
    parameter int unsigned DIST_W       = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              echo,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              busy,
    output logic              err_timeout
);

    import echo_pkg::*;

    localparam int unsigned SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
    localparam int unsigned TMO_W = $clog2(max_u(RISE_TIMEOUT, MAX_ECHO));

    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [TMO_W-1:0] RISE_LAST = TMO_W'(RISE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] ECHO_LAST = TMO_W'(MAX_ECHO - 1);

    logic echo_s;
    logic rise;
    logic fall;

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [DIST_W-1:0] dist_cm_q, dist_cm_d;
    logic              dist_valid_q, dist_valid_d;
    logic              err_q, err_d;

    echo_sync u_sync (
        .clk    (clk),
        .clr    (clr),
        .echo   (echo),
        .echo_s (echo_s),
        .rise   (rise),
        .fall   (fall)
    );

    // State, counters and result registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= StIdle;
            tmo_q        <= '0;
            sub_q        <= '0;
            cm_q         <= '0;
            dist_cm_q    <= '0;
            dist_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            sub_q        <= sub_d;
            cm_q         <= cm_d;
            dist_cm_q    <= dist_cm_d;
            dist_valid_q <= dist_valid_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic: arm on start, count high time in 58-cycle chunks, bail out on timeouts.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        sub_d        = sub_q;
        cm_d         = cm_q;
        dist_cm_d    = dist_cm_q;
        dist_valid_d = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                // A rise coinciding with start is deliberately not seen by the next state.
                if (start) begin
                    state_d = StWaitRise;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            StWaitRise: begin
                if (rise) begin
                    // The rise cycle is already the first high cycle.
                    state_d = StMeasure;
                    sub_d   = SUB_W'(1);
                    cm_d    = '0;
                    tmo_d   = '0;
                end else if (tmo_q == RISE_LAST) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StMeasure: begin
                if (fall) begin
                    state_d      = StIdle;
                    dist_cm_d    = cm_q;
                    dist_valid_d = 1'b1;
                end else if (tmo_q == ECHO_LAST) begin
                    state_d = StWaitLow;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        cm_d  = (cm_q == '1) ? cm_q : cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            StWaitLow: begin
                // Hold off until the stale echo drops so it cannot re-arm a measurement.
                if (!echo_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs come straight from registers; busy is any non-idle state.
    always_comb begin
        dist_cm     = dist_cm_q;
        dist_valid  = dist_valid_q;
        err_timeout = err_q;
        busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_echo_receiver.sv
// Self-checking bench for echo_receiver: scoreboard of expected distances plus per-scenario checks.
module tb_echo_receiver;

    import echo_pkg::*;

    localparam int unsigned HALF = CLK_PERIOD_NS / 2;

    logic       clk   = 1'b0;
    logic       clr   = 1'b0;
    logic       start = 1'b0;
    logic       echo  = 1'b0;
    logic [8:0] dist_cm;
    logic       dist_valid;
    logic       busy;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_v;

    echo_receiver #(
        .US_PER_CM    (58),
        .RISE_TIMEOUT (1000),
        .MAX_ECHO     (30000),
        .DIST_W       (9)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .echo        (echo),
        .dist_cm     (dist_cm),
        .dist_valid  (dist_valid),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #(HALF) clk = ~clk;

    // Scoreboard: every dist_valid pops one expected distance.
    always @(negedge clk) begin
        if (clr && dist_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got dist_cm=%0d, required no dist_valid", dist_cm);
            end else begin
                exp_v = exp_q.pop_front();
                if (dist_cm !== 9'(exp_v)) begin
                    errors++;
                    $display("FAIL dist_cm: got %0d, required %0d", dist_cm, exp_v);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_valid: got %b, required 0", busy);
            end
            checks++;
            if (err_timeout !== 1'b0) begin
                errors++;
                $display("FAIL err_at_valid: got %b, required 0", err_timeout);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drive_echo(input int width);
        echo = 1'b1;
        tick(width);
        echo = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, required 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic test_reset();
        clr = 1'b0;
        tick(3);
        checks++;
        if (dist_cm !== 9'd0) begin
            errors++; $display("FAIL reset_dist_cm: got %0d, required 0", dist_cm);
        end
        checks++;
        if (dist_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dist_valid: got %b, required 0", dist_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, required 0", busy);
        end
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b, required 0", err_timeout);
        end
        clr = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        exp_q.push_back(10);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b, required 1", busy);
        end
        tick(200);
        drive_echo(580);
        drain(20);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL basic_err: got %b, required 0", err_timeout);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_rise_timeout();
        int n = 0;
        pulse_start();
        @(negedge clk);
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 1000) begin
            errors++; $display("FAIL rise_tmo_cycles: got %0d busy cycles, required 1000", n);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL rise_tmo_err: got %b, required 1", err_timeout);
        end
        checks++;
        if (dist_cm !== 9'd10) begin
            errors++; $display("FAIL rise_tmo_hold: got dist_cm=%0d, required 10", dist_cm);
        end
        tick(1);
    endtask

    task automatic test_boundaries();
        int w[4] = '{57, 58, 115, 116};
        int e[4] = '{0, 1, 1, 2};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            pulse_start();
            tick(5);
            drive_echo(w[i]);
            drain(20);
        end
    endtask

    task automatic test_echo_timeout();
        pulse_start();
        tick(10);
        echo = 1'b1;
        tick(29000);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL echo_tmo_early: got err=%b busy=%b, required err=0 busy=1",
                     err_timeout, busy);
        end
        tick(1500);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL echo_tmo_set: got err=%b busy=%b, required err=1 busy=1",
                     err_timeout, busy);
        end
        tick(9500);
        echo = 1'b0;
        tick(5);
        checks++;
        if (busy !== 1'b0 || err_timeout !== 1'b1 || dist_cm !== 9'd2) begin
            errors++;
            $display("FAIL echo_tmo_end: got busy=%b err=%b dist_cm=%0d, required 0 1 2",
                     busy, err_timeout, dist_cm);
        end
        pulse_start();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL echo_tmo_clear: got err=%b, required 0", err_timeout);
        end
        exp_q.push_back(1);
        tick(5);
        drive_echo(58);
        drain(20);
    endtask

    task automatic test_stale_high();
        echo = 1'b1;
        tick(5);
        pulse_start();
        tick(50);
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stale_wait: got busy=%b err=%b, required busy=1 err=0",
                     busy, err_timeout);
        end
        echo = 1'b0;
        tick(10);
        exp_q.push_back(5);
        echo = 1'b1;
        tick(150);
        // Start while busy must not restart the measurement.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(149);
        echo = 1'b0;
        drain(20);
    endtask

    task automatic test_clear();
        pulse_start();
        tick(5);
        echo = 1'b1;
        tick(400);
        #1;
        clr = 1'b0;
        #1;
        checks++;
        if (dist_cm !== 9'd0 || dist_valid !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL clr_async: got dist_cm=%0d valid=%b busy=%b err=%b, required all 0",
                     dist_cm, dist_valid, busy, err_timeout);
        end
        echo = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(3);
        exp_q.push_back(2);
        pulse_start();
        tick(5);
        drive_echo(116);
        drain(20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rise_timeout();
        test_boundaries();
        test_echo_timeout();
        test_stale_high();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
